lightgun_latch_sched: RTL and testbench
=======================================

Name: lightgun_latch_sched

Overview:
- Shares the single VDP2 external HV-counter latch (EXLAT) between two lightgun instances on controller ports 1 and 2.
- Each field, grants the latch to one port: fixed when only one port is enabled, alternating field-by-field when both are enabled.
- On that port's sensor rising edge, issues a timed active-low strobe and waits for the VDP2 latch acknowledge.
- Reports per-port "latched this field" flags to the SMPC/PDR port logic.
- Sits between the lightgun instances and the VDP2/SMPC glue.

Parameters:
- STROBE_LEN, 4, EXLAT_N low time in CE_PIX ticks (1..15)
- ACK_TIMEOUT, 64, CE_PIX ticks to wait for LATCH_ACK before abandoning (1..255)

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- CE_PIX  in  1  pixel clock enable
- VDE  in  1  vertical display enable; rising edge = field start
- EN_P1  in  1  port 1 has a lightgun attached
- EN_P2  in  1  port 2 has a lightgun attached
- SENSOR_P1  in  1  sensor output of port 1 lightgun
- SENSOR_P2  in  1  sensor output of port 2 lightgun
- LATCH_ACK  in  1  one-CLK pulse from VDP2: HV counter latched
- EXLAT_N  out  1  external latch strobe to VDP2, active low
- GRANT_P2  out  1  current field's grant: 0 = port 1, 1 = port 2
- LATCHED_P1  out  1  port 1 latch acknowledged this field
- LATCHED_P2  out  1  port 2 latch acknowledged this field
- BUSY  out  1  state is not IDLE/DONE

Behaviour:
Reset values:
- EXLAT_N=1, GRANT_P2=0, LATCHED_P1=0, LATCHED_P2=0, BUSY=0.
- State IDLE; internal counters 0; last-grant register = port 2, so the first dual-port field grants port 1.

Field start:
- Registered detect of VDE 0->1, sampled only on CE_PIX.
- On field start in any state:
  - clear both LATCHED flags;
  - force EXLAT_N=1;
  - choose the grant:
    - both enabled -> opposite of last grant;
    - only P1 -> P1;
    - only P2 -> P2;
    - none -> go to IDLE and leave the grant unchanged.
  - Update GRANT_P2 and the last-grant register, then go to ARMED.
- A field start aborts STROBE/WAIT; a field start is the only exit from DONE.

Sensor edges:
- SENSOR_x is registered once per CLK. A rising edge = previous 0, current 1.
- Edge detect is evaluated every CLK, independent of CE_PIX, so a sub-pixel pulse is not missed.
- A sensor already high on entry to ARMED is not an edge.

States:
- IDLE: EXLAT_N=1. Wait for field start.
- ARMED: Watch only the granted port's sensor. On a rising edge, go to STROBE next CLK: EXLAT_N=0, strobe counter=0. The non-granted port is ignored.
- STROBE: Counter increments on CE_PIX. When counter == STROBE_LEN-1 and CE_PIX: EXLAT_N=1, timeout counter=0, go to WAIT. LATCH_ACK seen during STROBE is remembered and honoured on entry to WAIT.
- WAIT: Timeout counter increments on CE_PIX.
  - LATCH_ACK (or remembered ack): set LATCHED_x for the granted port, go to DONE.
  - Counter reaches ACK_TIMEOUT: go to DONE with no flag.
  - Ack and timeout in the same cycle: the ack wins.
- DONE: EXLAT_N=1. Ignore sensors until the next field start. At most one strobe per field.

Enable changes:
- An EN_x change mid-field takes effect at the next field start.
- If the granted port's EN drops while ARMED, stay ARMED (harmless).

Async reset mid-strobe: EXLAT_N returns to 1 immediately.

Widths:
- Strobe counter 4 bits; timeout counter 8 bits, saturating.

Decomposition:
- Package lightgun_pkg:
  - enum typedef lgs_state_t {IDLE, ARMED, STROBE, WAIT, DONE};
  - localparams PORT1=1'b0, PORT2=1'b1.
- Natural sub-module: lightgun_edge_det, a per-port registered rising-edge detector with async active-low reset; instantiate twice.
- FSM, counters and grant logic stay in the top.

Test Plan:
1. Reset:
   - Stimulus: RST_N low, then release; EN_P1=1, EN_P2=0; one VDE rise; SENSOR_P1 pulse.
   - Response: EXLAT_N low for exactly 4 CE_PIX ticks. LATCH_ACK 2 ticks later -> LATCHED_P1=1, LATCHED_P2=0, BUSY=0.
2. Dual-port alternation:
   - Stimulus: both enabled; 4 fields; both sensors pulse every field; ack each strobe.
   - Response: GRANT_P2 = 0,1,0,1. Latched flags alternate P1,P2,P1,P2. One strobe per field.
3. Timeout:
   - Stimulus: strobe issued, no LATCH_ACK.
   - Response: DONE after 64 CE_PIX ticks; both flags 0; second sensor edge in the same field -> no strobe.
4. Field abort:
   - Stimulus: VDE rises during STROBE, 2 ticks into the strobe.
   - Response: EXLAT_N=1 the same CLK; flags cleared; state ARMED with the new grant.
5. Early ack and simultaneity:
   - Stimulus: LATCH_ACK during STROBE.
   - Response: LATCHED set on entry to WAIT.
   - Stimulus: ack and timeout in the same cycle.
   - Response: flag set.
6. Held sensor / async reset:
   - Stimulus: SENSOR_P1 high across the field start.
   - Response: no strobe until it falls and rises again.
   - Stimulus: RST_N low while EXLAT_N=0.
   - Response: EXLAT_N=1 without a clock edge.

Source files
------------

// File: rtl/lightgun_pkg.sv
// Shared types and constants for the dual-port lightgun EXLAT scheduler.
package lightgun_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    STROBE = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } lgs_state_t;

  localparam logic PORT1 = 1'b0;
  localparam logic PORT2 = 1'b1;

  localparam int STROBE_CNT_W  = 4;
  localparam int TIMEOUT_CNT_W = 8;

  function automatic logic [TIMEOUT_CNT_W-1:0] sat_inc_to(input logic [TIMEOUT_CNT_W-1:0] v);
    sat_inc_to = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/lightgun_edge_det.sv
// Registered rising-edge detector for one lightgun sensor line, evaluated every CLK.
module lightgun_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_rise
);

  logic r_cur;
  logic r_prev;

  // Two-stage sample: current and previous sensor level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cur  <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_cur  <= i_sig;
      r_prev <= r_cur;
    end
  end

  assign o_rise = r_cur & ~r_prev;

endmodule

// File: rtl/lightgun_latch_sched.sv
// Grants the single VDP2 EXLAT input to one of two lightgun ports per field,
// issues the timed strobe on that port's sensor edge and tracks the latch ack.
module lightgun_latch_sched
  import lightgun_pkg::*;
#(
  parameter int STROBE_LEN  = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ce_pix,
  input  logic i_vde,
  input  logic i_en_p1,
  input  logic i_en_p2,
  input  logic i_sensor_p1,
  input  logic i_sensor_p2,
  input  logic i_latch_ack,
  output logic o_exlat_n,
  output logic o_grant_p2,
  output logic o_latched_p1,
  output logic o_latched_p2,
  output logic o_busy
);

  localparam logic [STROBE_CNT_W-1:0]  STROBE_LAST = STROBE_CNT_W'(STROBE_LEN - 1);
  localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_LIM = TIMEOUT_CNT_W'(ACK_TIMEOUT);

  lgs_state_t r_state;
  lgs_state_t w_next;

  logic                     r_vde;
  logic                     r_grant_p2;
  logic                     r_last_grant;
  logic                     r_ack_seen;
  logic [STROBE_CNT_W-1:0]  r_strobe_cnt;
  logic [TIMEOUT_CNT_W-1:0] r_to_cnt;
  logic                     r_exlat_n;
  logic                     r_latched_p1;
  logic                     r_latched_p2;
  logic                     r_busy;

  logic                     w_rise_p1;
  logic                     w_rise_p2;
  logic                     w_rise_grant;
  logic                     w_field_start;
  logic                     w_any_en;
  logic                     w_new_grant;
  logic                     w_ack_any;
  logic                     w_strobe_end;
  logic                     w_timeout;
  logic [TIMEOUT_CNT_W-1:0] w_to_inc;
  logic                     w_exlat_n_d;
  logic                     w_busy_d;
  logic                     w_latched_p1_d;
  logic                     w_latched_p2_d;

  lightgun_edge_det u_edge_p1 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sig   (i_sensor_p1),
    .o_rise  (w_rise_p1)
  );

  lightgun_edge_det u_edge_p2 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sig   (i_sensor_p2),
    .o_rise  (w_rise_p2)
  );

  assign w_field_start = i_ce_pix & i_vde & ~r_vde;
  assign w_any_en      = i_en_p1 | i_en_p2;
  // Dual-port fields alternate; a single enabled port always wins.
  assign w_new_grant   = (i_en_p1 & i_en_p2) ? ~r_last_grant : i_en_p2;
  assign w_rise_grant  = (r_grant_p2 == PORT2) ? w_rise_p2 : w_rise_p1;
  assign w_ack_any     = i_latch_ack | r_ack_seen;
  assign w_strobe_end  = i_ce_pix & (r_strobe_cnt == STROBE_LAST);
  assign w_to_inc      = sat_inc_to(r_to_cnt);
  assign w_timeout     = i_ce_pix & (w_to_inc >= TIMEOUT_LIM);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic; a field start overrides every state.
  always_comb begin
    w_next = r_state;
    if (w_field_start) begin
      w_next = w_any_en ? ARMED : IDLE;
    end else begin
      case (r_state)
        IDLE:    w_next = IDLE;
        ARMED:   w_next = w_rise_grant ? STROBE : ARMED;
        STROBE:  w_next = w_strobe_end ? WAIT : STROBE;
        WAIT:    w_next = (w_ack_any || w_timeout) ? DONE : WAIT;
        DONE:    w_next = DONE;
        default: w_next = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    w_exlat_n_d    = (w_next != STROBE);
    w_busy_d       = (w_next == ARMED) || (w_next == STROBE) || (w_next == WAIT);
    w_latched_p1_d = r_latched_p1;
    w_latched_p2_d = r_latched_p2;
    if (w_field_start) begin
      w_latched_p1_d = 1'b0;
      w_latched_p2_d = 1'b0;
    end else if ((r_state == WAIT) && w_ack_any) begin
      if (r_grant_p2 == PORT2) w_latched_p2_d = 1'b1;
      else                     w_latched_p1_d = 1'b1;
    end else begin
      w_latched_p1_d = r_latched_p1;
      w_latched_p2_d = r_latched_p2;
    end
  end

  // Registered outputs, field detect, grant and per-state counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_exlat_n    <= 1'b1;
      r_busy       <= 1'b0;
      r_latched_p1 <= 1'b0;
      r_latched_p2 <= 1'b0;
      r_vde        <= 1'b0;
      r_grant_p2   <= PORT1;
      r_last_grant <= PORT2;
      r_ack_seen   <= 1'b0;
      r_strobe_cnt <= 4'd0;
      r_to_cnt     <= 8'd0;
    end else begin
      r_exlat_n    <= w_exlat_n_d;
      r_busy       <= w_busy_d;
      r_latched_p1 <= w_latched_p1_d;
      r_latched_p2 <= w_latched_p2_d;
      if (i_ce_pix) r_vde <= i_vde;
      if (w_field_start && w_any_en) begin
        r_grant_p2   <= w_new_grant;
        r_last_grant <= w_new_grant;
      end
      // An ack arriving mid-strobe is held until WAIT can consume it.
      r_ack_seen <= (r_state == STROBE) ? (r_ack_seen | i_latch_ack) : 1'b0;
      if (r_state != STROBE) r_strobe_cnt <= 4'd0;
      else if (i_ce_pix)     r_strobe_cnt <= r_strobe_cnt + 4'd1;
      if (r_state != WAIT)   r_to_cnt <= 8'd0;
      else if (i_ce_pix)     r_to_cnt <= w_to_inc;
    end
  end

  assign o_exlat_n    = r_exlat_n;
  assign o_grant_p2   = r_grant_p2;
  assign o_latched_p1 = r_latched_p1;
  assign o_latched_p2 = r_latched_p2;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_lightgun_latch_sched.sv
// Self-checking bench for lightgun_latch_sched: per-field vector table with a
// scoreboard, plus hand sequences for abort, early ack, timeout edge, held sensor, reset.
module tb_lightgun_latch_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;
  logic vde = 1'b0;
  logic en_p1 = 1'b0;
  logic en_p2 = 1'b0;
  logic sens_p1 = 1'b0;
  logic sens_p2 = 1'b0;
  logic ack = 1'b0;
  logic exlat_n, grant_p2, latched_p1, latched_p2, busy;

  int checks = 0;
  int errors = 0;
  int mon_strobes = 0;
  int mon_cur_len = 0;
  int mon_last_len = 0;
  logic mon_prev = 1'b1;
  int ce_phase = 0;

  typedef struct {
    bit en1, en2, s1, s2, do_ack;
    bit exp_grant, exp_l1, exp_l2, exp_busy;
    int exp_strobes;
  } vec_t;

  typedef struct {
    int id;
    bit grant, l1, l2, busy;
    int strobes;
    int base;
  } exp_t;

  vec_t vecs[11];
  exp_t sb[$];

  lightgun_latch_sched #(.STROBE_LEN(4), .ACK_TIMEOUT(64)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_ce_pix     (ce),
    .i_vde        (vde),
    .i_en_p1      (en_p1),
    .i_en_p2      (en_p2),
    .i_sensor_p1  (sens_p1),
    .i_sensor_p2  (sens_p2),
    .i_latch_ack  (ack),
    .o_exlat_n    (exlat_n),
    .o_grant_p2   (grant_p2),
    .o_latched_p1 (latched_p1),
    .o_latched_p2 (latched_p2),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  // Pixel enable on every other clock.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      ce_phase = ce_phase + 1;
      ce = (ce_phase % 2 == 1);
    end
  end

  // Strobe monitor: counts strobes and the low time of each in CE ticks.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_prev = 1'b1;
      end else begin
        if (exlat_n == 1'b0 && mon_prev == 1'b1) begin
          mon_strobes = mon_strobes + 1;
          mon_cur_len = 0;
        end
        if (exlat_n == 1'b0 && ce == 1'b1) mon_cur_len = mon_cur_len + 1;
        if (exlat_n == 1'b1 && mon_prev == 1'b0) mon_last_len = mon_cur_len;
        mon_prev = exlat_n;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check1(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_exlat(input logic lvl, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (exlat_n === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    clocks(1);
    ack = 1'b0;
  endtask

  task automatic pulse_sensors(input bit s1, input bit s2);
    sens_p1 = s1;
    sens_p2 = s2;
    clocks(2);
    sens_p1 = 1'b0;
    sens_p2 = 1'b0;
  endtask

  // Start a field: VDE rises, sampled on the next pixel enable.
  task automatic field_start();
    vde = 1'b1;
    clocks(3);
  endtask

  // Count pixel-enable ticks from the current negedge until the n-th upcoming tick.
  task automatic ticks_until(input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 4 * n + 8; i++) begin
      if (ce) cnt = cnt + 1;
      if (cnt == n) break;
      @(negedge clk);
    end
  endtask

  task automatic check_field();
    exp_t e;
    e = sb.pop_front();
    check1($sformatf("f%0d_grant", e.id), int'(grant_p2), int'(e.grant));
    check1($sformatf("f%0d_latched_p1", e.id), int'(latched_p1), int'(e.l1));
    check1($sformatf("f%0d_latched_p2", e.id), int'(latched_p2), int'(e.l2));
    check1($sformatf("f%0d_busy", e.id), int'(busy), int'(e.busy));
    check1($sformatf("f%0d_strobes", e.id), mon_strobes - e.base, e.strobes);
    if (e.strobes == 1) check1($sformatf("f%0d_strobe_len", e.id), mon_last_len, 4);
  endtask

  task automatic run_field(input vec_t v, input int idx);
    exp_t e;
    bit ok;
    vde = 1'b0;
    en_p1 = v.en1;
    en_p2 = v.en2;
    clocks(4);
    e.id = idx; e.grant = v.exp_grant; e.l1 = v.exp_l1; e.l2 = v.exp_l2;
    e.busy = v.exp_busy; e.strobes = v.exp_strobes; e.base = mon_strobes;
    sb.push_back(e);
    field_start();
    clocks(1);
    pulse_sensors(v.s1, v.s2);
    wait_exlat(1'b0, 20, ok);
    if (ok) begin
      wait_exlat(1'b1, 40, ok);
      if (!ok) check1($sformatf("f%0d_exlat_release", idx), 0, 1);
      if (v.do_ack) begin
        clocks(4);
        pulse_ack();
      end else begin
        clocks(160);
      end
    end
    clocks(6);
    pulse_sensors(v.s1, v.s2);
    clocks(20);
    check_field();
  endtask

  function automatic vec_t mk(input bit en1, input bit en2, input bit s1, input bit s2,
                              input bit do_ack, input bit g, input bit l1, input bit l2,
                              input bit b, input int n);
    vec_t v;
    v.en1 = en1; v.en2 = en2; v.s1 = s1; v.s2 = s2; v.do_ack = do_ack;
    v.exp_grant = g; v.exp_l1 = l1; v.exp_l2 = l2; v.exp_busy = b; v.exp_strobes = n;
    return v;
  endfunction

  initial begin
    bit ok;
    int base;
    //            en1   en2   s1    s2    ack   grant l1    l2    busy  strobes
    vecs[0]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    vecs[1]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    vecs[2]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    vecs[3]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    vecs[4]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    vecs[5]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    vecs[6]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    vecs[7]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    vecs[8]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    vecs[9]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    vecs[10] = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);

    clocks(3);
    check1("rst_exlat_n", int'(exlat_n), 1);
    check1("rst_grant", int'(grant_p2), 0);
    check1("rst_latched_p1", int'(latched_p1), 0);
    check1("rst_latched_p2", int'(latched_p2), 0);
    check1("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    clocks(2);

    for (int i = 0; i < 11; i++) run_field(vecs[i], i);

    // Field abort two ticks into a strobe.
    en_p1 = 1'b1; en_p2 = 1'b0;
    vde = 1'b0; clocks(4); field_start(); vde = 1'b0; clocks(4);
    pulse_sensors(1'b1, 1'b0);
    wait_exlat(1'b0, 20, ok);
    check1("abort_strobe_start", int'(ok), 1);
    ticks_until(3);
    check1("abort_pre_low", int'(exlat_n), 0);
    vde = 1'b1;
    clocks(1);
    check1("abort_exlat_n", int'(exlat_n), 1);
    check1("abort_busy", int'(busy), 1);
    check1("abort_grant", int'(grant_p2), 0);
    clocks(1); vde = 1'b0; clocks(4);
    pulse_sensors(1'b1, 1'b0);
    wait_exlat(1'b0, 20, ok);
    wait_exlat(1'b1, 40, ok);
    clocks(2); pulse_ack(); clocks(3);
    check1("rearm_latched_p1", int'(latched_p1), 1);
    field_start();
    check1("newfield_flags_cleared", int'(latched_p1), 0);
    check1("newfield_busy", int'(busy), 1);

    // Ack arriving during the strobe is honoured on entering WAIT.
    vde = 1'b0; clocks(4);
    pulse_sensors(1'b1, 1'b0);
    wait_exlat(1'b0, 20, ok);
    clocks(2); pulse_ack();
    wait_exlat(1'b1, 40, ok);
    check1("early_ack_release", int'(ok), 1);
    clocks(3);
    check1("early_ack_latched", int'(latched_p1), 1);
    check1("early_ack_busy", int'(busy), 0);

    // Ack exactly on the timeout tick wins; one tick later it is too late.
    for (int late = 0; late < 2; late++) begin
      field_start(); vde = 1'b0; clocks(4);
      pulse_sensors(1'b1, 1'b0);
      wait_exlat(1'b0, 20, ok);
      wait_exlat(1'b1, 40, ok);
      ticks_until(64 + late);
      pulse_ack();
      clocks(3);
      check1($sformatf("timeout_edge%0d_latched", late), int'(latched_p1), (late == 0) ? 1 : 0);
      check1($sformatf("timeout_edge%0d_busy", late), int'(busy), 0);
    end

    // Sensor held high across the field start is not an edge.
    sens_p1 = 1'b1; clocks(3);
    field_start(); vde = 1'b0;
    base = mon_strobes;
    clocks(20);
    check1("held_no_strobe", mon_strobes - base, 0);
    check1("held_busy", int'(busy), 1);
    sens_p1 = 1'b0; clocks(3);
    pulse_sensors(1'b1, 1'b0);
    wait_exlat(1'b0, 20, ok);
    check1("held_then_edge_strobe", mon_strobes - base, 1);

    // Async reset while the strobe is low.
    check1("areset_pre_low", int'(exlat_n), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check1("areset_exlat_n", int'(exlat_n), 1);
    check1("areset_busy", int'(busy), 0);
    check1("areset_latched_p1", int'(latched_p1), 0);
    clocks(2);
    rst_n = 1'b1;
    clocks(2);

    // After reset the first dual-port field grants port 1.
    run_field(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1), 11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
